fp_mult_seq: RTL and testbench

Parametrised, handshaked, multi-cycle IEEE-754 binary floating-point multiplier. It generalises the single-precision combinational multiplier to any exponent and fraction width. It computes the significand product with an iterative shift-add datapath and adds four rounding modes, special-value handling and exception flags. It sits between operand-issue logic and result consumers in the FP datapath and uses a valid/ready handshake on both sides.

---
 rtl/fp_mult_seq_if.sv | 35 +++
 rtl/fp_mult_seq.sv | 190 +++++++++++++++++++
 tb/tb_fp_mult_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mult_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_mult_seq_if : operand/result valid-ready bundle for fp_mult_seq
// Revision 1.0
// ---------------------------------------------------------------------------
interface fp_mult_seq_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int W = EXP_W + FRAC_W + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         inexact;
  logic         invalid;

  modport master (
    output in_valid, a, b, rnd_mode, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact, invalid
  );

  modport slave (
    input  in_valid, a, b, rnd_mode, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact, invalid
  );
endinterface
`default_nettype wire

// File: rtl/fp_mult_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_mult_seq : handshaked multi-cycle IEEE-754 multiplier, shift-add core
// Revision 1.0
// ---------------------------------------------------------------------------
module fp_mult_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fp_mult_seq_if.slave  bus
);
  localparam int W     = EXP_W + FRAC_W + 1;
  localparam int N     = FRAC_W + 1;
  localparam int EW2   = EXP_W + 2;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(N - 1);
  localparam logic [EW2-1:0]   c_bias     = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW2-1:0]   c_emax     = EW2'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     c_qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, NORM = 2'd2, DONE = 2'd3} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_pend;
  logic [W-1:0]     r_a, r_b;
  logic [1:0]       r_mode;
  logic [N-1:0]     r_ma, r_mb;
  logic [2*N-1:0]   r_p;
  logic [CNT_W-1:0] r_cnt;
  logic [EW2-1:0]   r_e;
  logic [W-1:0]     r_result;
  logic             r_ovf, r_unf, r_inx, r_inv;

  // Operand classification works on the latched copies, one cycle after acceptance
  logic [EXP_W-1:0] w_ea, w_eb;
  logic             w_sign, w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_special;
  assign w_ea      = r_a[W-2:FRAC_W];
  assign w_eb      = r_b[W-2:FRAC_W];
  assign w_sign    = r_a[W-1] ^ r_b[W-1];
  assign w_zero_a  = (w_ea == '0);
  assign w_zero_b  = (w_eb == '0);
  assign w_inf_a   = (&w_ea) && (r_a[FRAC_W-1:0] == '0);
  assign w_inf_b   = (&w_eb) && (r_b[FRAC_W-1:0] == '0);
  assign w_nan_a   = (&w_ea) && (r_a[FRAC_W-1:0] != '0);
  assign w_nan_b   = (&w_eb) && (r_b[FRAC_W-1:0] != '0);
  assign w_special = w_zero_a | w_zero_b | (&w_ea) | (&w_eb);

  logic [W-1:0] w_spec_res;
  logic         w_spec_inv;
  always_comb begin
    w_spec_res = {w_sign, {(W-1){1'b0}}};
    w_spec_inv = 1'b0;
    if (w_nan_a | w_nan_b) begin
      w_spec_res = c_qnan;
    end else if ((w_zero_a & w_inf_b) | (w_inf_a & w_zero_b)) begin
      w_spec_res = c_qnan;
      w_spec_inv = 1'b1;
    end else if (w_inf_a | w_inf_b) begin
      w_spec_res = {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end
  end

  // Right-shifting accumulator: the upper half absorbs one partial product per cycle
  logic [N:0] w_sum;
  assign w_sum = {1'b0, r_p[2*N-1:N]} + (r_mb[0] ? {1'b0, r_ma} : '0);

  logic [2*N-1:0]    w_pn;
  logic              w_top, w_guard, w_sticky, w_inc, w_carry, w_ovf, w_unf;
  logic [N-1:0]      w_sig;
  logic [FRAC_W-1:0] w_frac;
  logic [EW2-1:0]    w_e_fin;
  logic [W-1:0]      w_inf, w_max, w_norm_res;
  always_comb begin
    w_top    = r_p[2*N-1];
    w_pn     = w_top ? r_p : {r_p[2*N-2:0], 1'b0};
    w_sig    = w_pn[2*N-1:N];
    w_guard  = w_pn[N-1];
    w_sticky = |w_pn[N-2:0];
    w_inc    = 1'b0;
    case (r_mode)
      2'b00:   w_inc = w_guard & (w_sticky | w_sig[0]);
      2'b01:   w_inc = 1'b0;
      2'b10:   w_inc = ~w_sign & (w_guard | w_sticky);
      default: w_inc = w_sign & (w_guard | w_sticky);
    endcase
    // An all-ones significand that rounds up wraps its fraction to zero and bumps e
    w_carry = (&w_sig) & w_inc;
    w_frac  = w_sig[FRAC_W-1:0] + {{(FRAC_W-1){1'b0}}, w_inc};
    w_e_fin = r_e + {{(EW2-1){1'b0}}, w_top} + {{(EW2-1){1'b0}}, w_carry};
    w_ovf   = ~w_e_fin[EW2-1] && (w_e_fin >= c_emax);
    w_unf   = w_e_fin[EW2-1] || (w_e_fin == '0);
    w_inf   = {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    w_max   = {w_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
    if (w_ovf) begin
      case (r_mode)
        2'b00:   w_norm_res = w_inf;
        2'b01:   w_norm_res = w_max;
        2'b10:   w_norm_res = w_sign ? w_max : w_inf;
        default: w_norm_res = w_sign ? w_inf : w_max;
      endcase
    end else if (w_unf) begin
      w_norm_res = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_norm_res = {w_sign, w_e_fin[EXP_W-1:0], w_frac};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_pend) w_state_nxt = w_special ? DONE : MUL;
      MUL:     if (r_cnt == c_cnt_last) w_state_nxt = NORM;
      NORM:    w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pend   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_e      <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inx    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_mode <= bus.rnd_mode;
            r_pend <= 1'b1;
          end
          if (r_pend) begin
            r_pend <= 1'b0;
            if (w_special) begin
              r_result <= w_spec_res;
              r_ovf    <= 1'b0;
              r_unf    <= 1'b0;
              r_inx    <= 1'b0;
              r_inv    <= w_spec_inv;
            end else begin
              r_ma  <= {1'b1, r_a[FRAC_W-1:0]};
              r_mb  <= {1'b1, r_b[FRAC_W-1:0]};
              r_p   <= '0;
              r_cnt <= '0;
              r_e   <= {2'b00, w_ea} + {2'b00, w_eb} - c_bias;
            end
          end
        end
        MUL: begin
          r_p   <= {w_sum, r_p[N-1:1]};
          r_mb  <= {1'b0, r_mb[N-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        NORM: begin
          r_result <= w_norm_res;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_inx    <= w_guard | w_sticky | w_ovf | w_unf;
          r_inv    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !r_pend;
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
  assign bus.inexact   = r_inx;
  assign bus.invalid   = r_inv;
endmodule
`default_nettype wire

// File: tb/tb_fp_mult_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fp_mult_seq : single and half precision instances vs arithmetic model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fp_mult_seq;
  logic clk = 1'b0;
  logic rst;
  logic out_rdy;
  always #5 clk = ~clk;

  fp_mult_seq_if #(.EXP_W(8), .FRAC_W(23)) fb ();
  fp_mult_seq_if #(.EXP_W(5), .FRAC_W(10)) hb ();
  assign fb.out_ready = out_rdy;
  assign hb.out_ready = out_rdy;

  fp_mult_seq #(.EXP_W(8), .FRAC_W(23)) u_dut_sp (.clk(clk), .rst(rst), .bus(fb));
  fp_mult_seq #(.EXP_W(5), .FRAC_W(10)) u_dut_hp (.clk(clk), .rst(rst), .bus(hb));

  int n_checks = 0;
  int n_fail   = 0;
  bit sel_h    = 1'b0;

  logic        obs_ready, obs_valid;
  logic [31:0] obs_result;
  logic [3:0]  obs_flags;
  always_comb begin
    obs_ready  = sel_h ? hb.in_ready  : fb.in_ready;
    obs_valid  = sel_h ? hb.out_valid : fb.out_valid;
    obs_result = sel_h ? {16'h0, hb.result} : fb.result;
    obs_flags  = sel_h ? {hb.overflow, hb.underflow, hb.inexact, hb.invalid}
                       : {fb.overflow, fb.underflow, fb.inexact, fb.invalid};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_in(input bit h, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] m);
    if (h) begin
      hb.in_valid = v; hb.a = a[15:0]; hb.b = b[15:0]; hb.rnd_mode = m;
    end else begin
      fb.in_valid = v; fb.a = a; fb.b = b; fb.rnd_mode = m;
    end
  endtask

  // Reference: exact integer product, then normalise/round by comparing the remainder to half an ulp
  function automatic void ref_mul(input int ew, input int fw, input logic [63:0] a,
                                  input logic [63:0] b, input logic [1:0] m,
                                  output logic [63:0] r, output logic [3:0] f, output bit spec);
    logic [63:0] emax, fmask, ea, eb, fa, fb_, s, prod, q, rem, half, qnan, inf, mx;
    longint e;
    int sh;
    bit up, toinf;
    emax  = (64'd1 << ew) - 1;
    fmask = (64'd1 << fw) - 1;
    ea = (a >> fw) & emax;  eb = (b >> fw) & emax;
    fa = a & fmask;         fb_ = b & fmask;
    s  = ((a >> (ew + fw)) ^ (b >> (ew + fw))) & 64'd1;
    qnan = (emax << fw) | (64'd1 << (fw - 1));
    inf  = (s << (ew + fw)) | (emax << fw);
    mx   = (s << (ew + fw)) | ((emax - 1) << fw) | fmask;
    f = 4'b0000;
    spec = 1'b1;
    if ((ea == emax && fa != 0) || (eb == emax && fb_ != 0)) r = qnan;
    else if ((ea == 0 && eb == emax) || (ea == emax && eb == 0)) begin r = qnan; f = 4'b0001; end
    else if (ea == emax || eb == emax) r = inf;
    else if (ea == 0 || eb == 0) r = s << (ew + fw);
    else begin
      spec = 1'b0;
      prod = ((64'd1 << fw) | fa) * ((64'd1 << fw) | fb_);
      e = longint'(ea) + longint'(eb) - ((longint'(1) << (ew - 1)) - 1);
      if (prod >= (64'd1 << (2 * fw + 1))) begin sh = fw + 1; e = e + 1; end
      else sh = fw;
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      case (m)
        2'b00:   up = (rem > half) || (rem == half && q[0]);
        2'b01:   up = 1'b0;
        2'b10:   up = (s == 0) && (rem != 0);
        default: up = (s == 1) && (rem != 0);
      endcase
      q = q + 64'(up);
      if (q == (64'd1 << (fw + 1))) begin q = q >> 1; e = e + 1; end
      if (e >= longint'(emax)) begin
        toinf = (m == 2'b00) || (m == 2'b10 && s == 0) || (m == 2'b11 && s == 1);
        r = toinf ? inf : mx;
        f = 4'b1010;
      end else if (e <= 0) begin
        r = s << (ew + fw);
        f = 4'b0110;
      end else begin
        r = (s << (ew + fw)) | (64'(e) << fw) | (q & fmask);
        f = {2'b00, rem != 0, 1'b0};
      end
    end
  endfunction

  function automatic logic [63:0] rand_operand(input int ew, input int fw);
    logic [63:0] emax, bias, e, fr, s;
    int sel;
    emax = (64'd1 << ew) - 1;
    bias = (64'd1 << (ew - 1)) - 1;
    sel  = int'($urandom_range(0, 19));
    s    = 64'($urandom_range(0, 1));
    fr   = {$urandom, $urandom} & ((64'd1 << fw) - 1);
    if (sel == 0)      e = 0;
    else if (sel == 1) begin e = emax; fr = 0; end
    else if (sel == 2) begin e = emax; fr = fr | 64'd1; end
    else if (sel == 3) begin e = bias; fr = (64'd1 << fw) - 1; end
    else if (sel < 10) e = 64'($urandom_range(1, int'(emax) - 1));
    else               e = bias - 6 + 64'($urandom_range(0, 12));
    return (s << (ew + fw)) | (e << fw) | fr;
  endfunction

  task automatic do_op(input bit h, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic [31:0] exp_r, input logic [3:0] exp_f,
                       input int exp_lat, input string tag);
    int n;
    sel_h = h;
    n = 0;
    while (!obs_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_rdy"}, 64'(obs_ready), 64'd1);
    drive_in(h, 1'b1, a, b, m);
    @(negedge clk);
    drive_in(h, 1'b0, $urandom, $urandom, 2'($urandom));
    check({tag, "_busy"}, 64'(obs_ready), 64'd0);
    n = 0;
    while (!obs_valid && n < 100) begin @(negedge clk); n++; end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_res"}, 64'(obs_result), 64'(exp_r));
    check({tag, "_flg"}, 64'(obs_flags), 64'(exp_f));
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
  endtask

  task automatic rand_op(input bit h, input string tag);
    logic [63:0] a, b, r;
    logic [3:0]  f;
    logic [1:0]  m;
    bit spec;
    int ew, fw;
    ew = h ? 5 : 8;
    fw = h ? 10 : 23;
    a = rand_operand(ew, fw);
    b = rand_operand(ew, fw);
    m = 2'($urandom);
    ref_mul(ew, fw, a, b, m, r, f, spec);
    do_op(h, a[31:0], b[31:0], m, r[31:0], f, spec ? 1 : fw + 3, tag);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    out_rdy = 1'b0;
    drive_in(1'b0, 1'b0, '0, '0, '0);
    drive_in(1'b1, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_ready",  64'(fb.in_ready), 64'd1);
    check("rst_valid",  64'(fb.out_valid), 64'd0);
    check("rst_result", 64'(fb.result), 64'd0);
    check("rst_flags",  64'({fb.overflow, fb.underflow, fb.inexact, fb.invalid}), 64'd0);
    check("rst_h_ready", 64'(hb.in_ready), 64'd1);
    check("rst_h_result", 64'(hb.result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(0, 32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000, 26, "basic");
    do_op(0, 32'h3FC00000, 32'h3FC00000, 2'b00, 32'h40100000, 4'b0000, 26, "norm");
    do_op(0, 32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0010, 26, "rne");
    do_op(0, 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0010, 26, "rup");
    do_op(0, 32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0010, 26, "rtz");
    do_op(0, 32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800003, 4'b0010, 26, "rdn");
    do_op(0, 32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 4'b1010, 26, "ovf_rne");
    do_op(0, 32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, 4'b1010, 26, "ovf_rtz");
    do_op(0, 32'h00800000, 32'h00800000, 2'b00, 32'h00000000, 4'b0110, 26, "unf");
    do_op(0, 32'h00000000, 32'h7F800000, 2'b00, 32'h7FC00000, 4'b0001, 1, "zero_inf");
    do_op(0, 32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000, 4'b0000, 1, "inf_fin");
    do_op(0, 32'h7FA00000, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b0000, 1, "nan");

    // Backpressure: result held, in_ready low, stray in_valid pulses ignored
    sel_h = 1'b0;
    drive_in(0, 1'b1, 32'h40400000, 32'h40000000, 2'b00);
    @(negedge clk);
    drive_in(0, 1'b0, '0, '0, '0);
    n = 0;
    while (!obs_valid && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(obs_valid), 64'd1);
      check("bp_res",   64'(obs_result), 64'h40C00000);
      check("bp_ready", 64'(obs_ready), 64'd0);
      drive_in(0, i[0], $urandom, $urandom, 2'($urandom));
      @(negedge clk);
    end
    drive_in(0, 1'b0, '0, '0, '0);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check("bp_next_ready", 64'(obs_ready), 64'd1);
    do_op(0, 32'h3FC00000, 32'h3FC00000, 2'b00, 32'h40100000, 4'b0000, 26, "bp_next");

    // Reset partway through MUL aborts without producing a result
    drive_in(0, 1'b1, 32'h40400000, 32'h40000000, 2'b00);
    @(negedge clk);
    drive_in(0, 1'b0, '0, '0, '0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready",  64'(obs_ready), 64'd1);
    check("abort_valid",  64'(obs_valid), 64'd0);
    check("abort_result", 64'(obs_result), 64'd0);
    check("abort_flags",  64'(obs_flags), 64'd0);
    n = 0;
    repeat (40) begin @(negedge clk); if (obs_valid) n++; end
    check("abort_no_valid", 64'(n), 64'd0);
    do_op(0, 32'h40400000, 32'h40000000, 2'b00, 32'h40C00000, 4'b0000, 26, "post_abort");

    do_op(1, 32'h4200, 32'h4000, 2'b00, 32'h4600, 4'b0000, 13, "h_basic");
    do_op(1, 32'h0000, 32'h7C00, 2'b00, 32'h7E00, 4'b0001, 1, "h_zero_inf");
    do_op(1, 32'hFC00, 32'h4000, 2'b00, 32'hFC00, 4'b0000, 1, "h_inf_fin");

    for (int i = 0; i < 40; i++) rand_op(0, $sformatf("rnd_sp%0d", i));
    for (int i = 0; i < 20; i++) rand_op(1, $sformatf("rnd_hp%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
